// File: rtl/axis_slave.sv
// AXI-Stream receive-side slave: buffers incoming beats in a first-word-fall-through FIFO,
// tracks tlast framing and tid consistency, and flags prolonged backend stalls.
module axis_slave #(
   parameter int         DEPTH       = 8,
   parameter logic [7:0] RDY_TIMEOUT = 8'd5
) (
   input  logic                       axi_aclk,
   input  logic                       axi_aresetn,
   input  logic                       axis_tvalid,
   input  logic [31:0]                axis_tdata,
   input  logic [3:0]                 axis_tstrb,
   input  logic [3:0]                 axis_tkeep,
   input  logic                       axis_tlast,
   input  logic [1:0]                 axis_tid,
   input  logic [1:0]                 axis_tuser,
   output logic                       axis_tready,
   output logic                       bk_valid,
   output logic [31:0]                bk_data,
   output logic [3:0]                 bk_tstrb,
   output logic [3:0]                 bk_tkeep,
   output logic                       bk_tlast,
   output logic [1:0]                 bk_tid,
   output logic [1:0]                 bk_user,
   input  logic                       bk_ready,
   input  logic                       bk_clear,
   output logic                       bk_done,
   output logic                       bk_nordy,
   output logic                       rx_busy,
   output logic [7:0]                 pkt_count,
   output logic                       tid_err,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH + 1);

   localparam logic RX_IDLE = 1'b0;
   localparam logic RX_PKT  = 1'b1;

   logic [44:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          ready_en;
   logic          state;
   logic [1:0]    tid_lat;
   logic [7:0]    stall_cnt;
   logic          wr;
   logic          pop;
   logic [44:0]   entry;
   logic [44:0]   head;

   // tready depends only on registered state and the flush request, never on tvalid
   assign axis_tready = ready_en & (level < LW'(DEPTH)) & ~bk_clear;
   assign wr          = axis_tvalid & axis_tready;
   assign pop         = bk_valid & bk_ready & ~bk_clear;
   assign entry       = {axis_tdata, axis_tstrb, axis_tkeep, axis_tid, axis_tuser, axis_tlast};

   assign bk_valid = (level != '0);
   assign head     = bk_valid ? mem[rd_ptr] : '0;
   assign bk_data  = head[44:13];
   assign bk_tstrb = head[12:9];
   assign bk_tkeep = head[8:5];
   assign bk_tid   = head[4:3];
   assign bk_user  = head[2:1];
   assign bk_tlast = head[0];
   assign bk_done  = pop & head[0];
   assign bk_nordy = (stall_cnt >= RDY_TIMEOUT);
   assign rx_busy  = (state == RX_PKT);

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr) begin
         mem[wr_ptr] <= entry;
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         ready_en  <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         stall_cnt <= '0;
      end else begin
         ready_en <= 1'b1;
         if (bk_clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            stall_cnt <= '0;
         end else begin
            if (wr) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({wr, pop})
               2'b10:   level <= level + 1'b1;
               2'b01:   level <= level - 1'b1;
               default: level <= level;
            endcase
            if (bk_valid && !bk_ready) begin
               if (stall_cnt != 8'hFF) stall_cnt <= stall_cnt + 8'd1;
            end else begin
               stall_cnt <= '0;
            end
         end
      end
   end

   // Framing tracker only moves on accepted beats; tid is captured at packet start
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state     <= RX_IDLE;
         tid_lat   <= '0;
         pkt_count <= '0;
         tid_err   <= 1'b0;
      end else if (bk_clear) begin
         state     <= RX_IDLE;
         pkt_count <= '0;
         tid_err   <= 1'b0;
      end else if (wr) begin
         if (axis_tlast) pkt_count <= pkt_count + 8'd1;
         case (state)
            RX_IDLE: begin
               if (!axis_tlast) begin
                  state   <= RX_PKT;
                  tid_lat <= axis_tid;
               end
            end
            default: begin
               if (axis_tid != tid_lat) tid_err <= 1'b1;
               if (axis_tlast) state <= RX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_slave.sv
// Directed self-checking bench for axis_slave: framing, backpressure, stall flag,
// pointer wrap, tid error, flush and asynchronous reset.
module tb_axis_slave;

   logic        clk;
   logic        rst_n;
   logic        axis_tvalid;
   logic [31:0] axis_tdata;
   logic [3:0]  axis_tstrb;
   logic [3:0]  axis_tkeep;
   logic        axis_tlast;
   logic [1:0]  axis_tid;
   logic [1:0]  axis_tuser;
   logic        axis_tready;
   logic        bk_valid;
   logic [31:0] bk_data;
   logic [3:0]  bk_tstrb;
   logic [3:0]  bk_tkeep;
   logic        bk_tlast;
   logic [1:0]  bk_tid;
   logic [1:0]  bk_user;
   logic        bk_ready;
   logic        bk_clear;
   logic        bk_done;
   logic        bk_nordy;
   logic        rx_busy;
   logic [7:0]  pkt_count;
   logic        tid_err;
   logic [3:0]  level;

   int n_cmp = 0;
   int n_err = 0;

   axis_slave #(.DEPTH(8), .RDY_TIMEOUT(8'd5)) dut (
      .axi_aclk   (clk),
      .axi_aresetn(rst_n),
      .axis_tvalid(axis_tvalid),
      .axis_tdata (axis_tdata),
      .axis_tstrb (axis_tstrb),
      .axis_tkeep (axis_tkeep),
      .axis_tlast (axis_tlast),
      .axis_tid   (axis_tid),
      .axis_tuser (axis_tuser),
      .axis_tready(axis_tready),
      .bk_valid   (bk_valid),
      .bk_data    (bk_data),
      .bk_tstrb   (bk_tstrb),
      .bk_tkeep   (bk_tkeep),
      .bk_tlast   (bk_tlast),
      .bk_tid     (bk_tid),
      .bk_user    (bk_user),
      .bk_ready   (bk_ready),
      .bk_clear   (bk_clear),
      .bk_done    (bk_done),
      .bk_nordy   (bk_nordy),
      .rx_busy    (rx_busy),
      .pkt_count  (pkt_count),
      .tid_err    (tid_err),
      .level      (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic l, input logic [1:0] id);
      axis_tvalid = v;
      axis_tdata  = d;
      axis_tlast  = l;
      axis_tid    = id;
   endtask

   initial begin
      int idx;
      logic acc;

      rst_n = 1'b0;
      bk_ready = 1'b0;
      bk_clear = 1'b0;
      axis_tstrb = 4'hF;
      axis_tkeep = 4'hA;
      axis_tuser = 2'd2;
      applyStimulus(1'b0, 32'h0, 1'b0, 2'd0);
      tick();
      tick();
      checkOutput("rst_tready", 32'(axis_tready), 32'd0);
      checkOutput("rst_bk_valid", 32'(bk_valid), 32'd0);
      checkOutput("rst_bk_data", bk_data, 32'd0);
      checkOutput("rst_level", 32'(level), 32'd0);
      checkOutput("rst_pkt_count", 32'(pkt_count), 32'd0);
      checkOutput("rst_nordy", 32'(bk_nordy), 32'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("release_tready_low", 32'(axis_tready), 32'd0);
      tick();
      checkOutput("release_tready_high", 32'(axis_tready), 32'd1);

      // three-beat packet with backend always ready
      $display("[TB] three-beat packet");
      bk_ready = 1'b1;
      applyStimulus(1'b1, 32'h11, 1'b0, 2'd0);
      tick();
      applyStimulus(1'b1, 32'h22, 1'b0, 2'd0);
      checkOutput("p1_data0", bk_data, 32'h11);
      checkOutput("p1_busy0", 32'(rx_busy), 32'd1);
      checkOutput("p1_tkeep", 32'(bk_tkeep), 32'hA);
      tick();
      applyStimulus(1'b1, 32'h33, 1'b1, 2'd0);
      checkOutput("p1_data1", bk_data, 32'h22);
      checkOutput("p1_level1", 32'(level), 32'd1);
      checkOutput("p1_busy1", 32'(rx_busy), 32'd1);
      checkOutput("p1_done1", 32'(bk_done), 32'd0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 2'd0);
      checkOutput("p1_data2", bk_data, 32'h33);
      checkOutput("p1_tlast2", 32'(bk_tlast), 32'd1);
      checkOutput("p1_done2", 32'(bk_done), 32'd1);
      checkOutput("p1_busy2", 32'(rx_busy), 32'd0);
      checkOutput("p1_pkt_count", 32'(pkt_count), 32'd1);
      tick();
      checkOutput("p1_empty", 32'(bk_valid), 32'd0);
      checkOutput("p1_done_off", 32'(bk_done), 32'd0);

      // fill to full with the backend stalled
      $display("[TB] backpressure");
      bk_ready = 1'b0;
      idx = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         applyStimulus(1'b1, 32'h100 + 32'(idx), 1'b0, 2'd0);
         acc = axis_tready;
         checkOutput($sformatf("fill_tready_%0d", cyc), 32'(acc), (cyc < 8) ? 32'd1 : 32'd0);
         tick();
         if (acc) idx++;
      end
      checkOutput("fill_accepted", 32'(idx), 32'd8);
      checkOutput("fill_level", 32'(level), 32'd8);
      checkOutput("fill_head", bk_data, 32'h100);
      bk_ready = 1'b1;
      #1;
      checkOutput("full_pop_tready", 32'(axis_tready), 32'd0);
      tick();
      bk_ready = 1'b0;
      checkOutput("after_pop_tready", 32'(axis_tready), 32'd1);
      checkOutput("after_pop_level", 32'(level), 32'd7);
      checkOutput("after_pop_head", bk_data, 32'h101);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 2'd0);
      checkOutput("ninth_level", 32'(level), 32'd8);
      bk_clear = 1'b1;
      #1;
      checkOutput("clear_tready", 32'(axis_tready), 32'd0);
      tick();
      bk_clear = 1'b0;
      checkOutput("clear_level", 32'(level), 32'd0);
      checkOutput("clear_busy", 32'(rx_busy), 32'd0);

      // stall timeout on one buffered beat
      $display("[TB] stall timeout");
      applyStimulus(1'b1, 32'hAA, 1'b1, 2'd0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 2'd0);
      tick(); tick(); tick(); tick();
      checkOutput("nordy_4", 32'(bk_nordy), 32'd0);
      tick();
      checkOutput("nordy_5", 32'(bk_nordy), 32'd1);
      bk_ready = 1'b1;
      #1;
      checkOutput("nordy_pop_done", 32'(bk_done), 32'd1);
      tick();
      checkOutput("nordy_drop", 32'(bk_nordy), 32'd0);
      checkOutput("nordy_level", 32'(level), 32'd0);
      bk_clear = 1'b1;
      tick();
      bk_clear = 1'b0;

      // continuous single-beat packets through a wrapping FIFO
      $display("[TB] streaming wrap");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 32'h200 + 32'(i), 1'b1, 2'd1);
         tick();
         checkOutput($sformatf("wrap_data_%0d", i), bk_data, 32'h200 + 32'(i));
         checkOutput($sformatf("wrap_level_%0d", i), 32'(level), 32'd1);
         checkOutput($sformatf("wrap_busy_%0d", i), 32'(rx_busy), 32'd0);
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 2'd0);
      checkOutput("wrap_pkt_count", 32'(pkt_count), 32'd12);
      checkOutput("wrap_tid", 32'(bk_tid), 32'd1);
      tick();
      checkOutput("wrap_drained", 32'(level), 32'd0);

      // tid changes inside a packet
      $display("[TB] tid error and flush");
      bk_ready = 1'b0;
      bk_clear = 1'b1;
      tick();
      bk_clear = 1'b0;
      applyStimulus(1'b1, 32'h301, 1'b0, 2'd1);
      tick();
      applyStimulus(1'b1, 32'h302, 1'b0, 2'd1);
      tick();
      checkOutput("tid_ok", 32'(tid_err), 32'd0);
      applyStimulus(1'b1, 32'h303, 1'b1, 2'd2);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 2'd0);
      checkOutput("tid_err_set", 32'(tid_err), 32'd1);
      checkOutput("tid_level", 32'(level), 32'd3);
      checkOutput("tid_pkt_count", 32'(pkt_count), 32'd1);
      bk_clear = 1'b1;
      tick();
      bk_clear = 1'b0;
      checkOutput("flush_tid_err", 32'(tid_err), 32'd0);
      checkOutput("flush_level", 32'(level), 32'd0);
      checkOutput("flush_pkt_count", 32'(pkt_count), 32'd0);
      checkOutput("flush_bk_valid", 32'(bk_valid), 32'd0);

      // asynchronous reset with a partial packet buffered
      $display("[TB] reset mid-packet");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'h400 + 32'(i), 1'b0, 2'd3);
         tick();
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 2'd0);
      checkOutput("pre_rst_level", 32'(level), 32'd4);
      checkOutput("pre_rst_busy", 32'(rx_busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_level", 32'(level), 32'd0);
      checkOutput("mid_rst_valid", 32'(bk_valid), 32'd0);
      checkOutput("mid_rst_data", bk_data, 32'd0);
      checkOutput("mid_rst_busy", 32'(rx_busy), 32'd0);
      checkOutput("mid_rst_tready", 32'(axis_tready), 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      checkOutput("rel2_tready_low", 32'(axis_tready), 32'd0);
      tick();
      checkOutput("rel2_tready_high", 32'(axis_tready), 32'd1);
      checkOutput("rel2_level", 32'(level), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
